// File: rtl/aes_sub_bytes_seq.sv
`default_nettype none
// ============================================================================
// Module      : aes_sub_bytes_seq
// Description : Iterative AES SubBytes / InvSubBytes stage. It substitutes
//               BYTES_PER_CYCLE bytes of the 128-bit state per clock and uses
//               valid/ready handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_sub_bytes_seq #(
    parameter int BYTES_PER_CYCLE = 4,
    parameter bit INVERSE         = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    localparam int c_NCYC = 16 / BYTES_PER_CYCLE;
    localparam int c_CW   = (c_NCYC > 1) ? $clog2(c_NCYC) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_NCYC - 1);

    // Entry x of each table sits at bits [2047-8x -: 8].
    localparam logic [2047:0] c_FWD_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] c_INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    localparam logic [2047:0] c_TABLE = INVERSE ? c_INV_SBOX : c_FWD_SBOX;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_CW-1:0]   r_cnt;
    logic [c_CW-1:0]   w_cnt_nxt;
    logic [127:0]      r_work;
    logic [127:0]      w_work_nxt;
    logic [127:0]      w_sub_work;

    logic [3:0]        w_k        [BYTES_PER_CYCLE];
    logic [7:0]        w_lane_in  [BYTES_PER_CYCLE];
    logic [7:0]        w_lane_out [BYTES_PER_CYCLE];

    // Byte k occupies bits [127-8k -: 8]; 127-8k == {~k, 3'b111} for a 4-bit k.
    generate
        for (genvar i = 0; i < BYTES_PER_CYCLE; i++) begin : g_lane
            assign w_k[i]        = 4'(int'(r_cnt) * BYTES_PER_CYCLE + i);
            assign w_lane_in[i]  = r_work[{~w_k[i], 3'b111} -: 8];
            assign w_lane_out[i] = c_TABLE[{~w_lane_in[i], 3'b111} -: 8];
        end
    endgenerate

    always_comb begin
        w_sub_work = r_work;
        for (int i = 0; i < BYTES_PER_CYCLE; i++) begin
            w_sub_work[{~w_k[i], 3'b111} -: 8] = w_lane_out[i];
        end
    end

    assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign state_out = r_work;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_work  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_work  <= w_work_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_work_nxt  = r_work;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                    w_work_nxt  = state_in;
                end
            end
            S_RUN: begin
                w_work_nxt = w_sub_work;
                if (r_cnt == c_LAST) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CW'(1);
                end
            end
            S_DONE: begin
                // Output handoff and next acceptance may share one edge.
                if (out_ready) begin
                    if (in_valid) begin
                        w_state_nxt = S_RUN;
                        w_cnt_nxt   = '0;
                        w_work_nxt  = state_in;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_sub_bytes_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_sub_bytes_seq
// Description : Scoreboard bench for aes_sub_bytes_seq over several
//               BYTES_PER_CYCLE / INVERSE configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_sub_bytes_seq;

    localparam int c_ND = 6;
    localparam logic [127:0] c_APPB_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] c_APPB_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

    logic         clk = 1'b0;
    logic         rst;
    logic         iv   [c_ND];
    logic         ordy [c_ND];
    logic [127:0] sin  [c_ND];
    logic [127:0] xin  [c_ND];
    logic         ir   [c_ND];
    logic         ov   [c_ND];
    logic         by   [c_ND];
    logic [127:0] so   [c_ND];

    int errors = 0;
    int checks = 0;
    bit drv_done;

    logic [7:0] fwd_t [256];
    logic [7:0] inv_t [256];

    always #5 clk = ~clk;

    function automatic int bpc_of(input int d);
        case (d)
            2:       return 1;
            3:       return 2;
            4:       return 8;
            5:       return 16;
            default: return 4;
        endcase
    endfunction

    task automatic check128(input string n, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic check_int(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    // Reference S-box built from GF(2^8) inversion plus the affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] r;
        r = (x == 8'h00) ? 8'h00 : 8'h01;
        if (x != 8'h00) for (int i = 0; i < 254; i++) r = gmul(r, x);
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_state(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++)
            o[127-8*k -: 8] = inv ? inv_t[s[127-8*k -: 8]] : fwd_t[s[127-8*k -: 8]];
        return o;
    endfunction

    generate
        for (genvar d = 0; d < c_ND; d++) begin : g_dut
            localparam int BPC = bpc_of(d);
            localparam int NC  = 16 / BPC;

            aes_sub_bytes_seq #(
                .BYTES_PER_CYCLE(BPC),
                .INVERSE        (d == 1)
            ) u_dut (
                .clk      (clk),
                .rst      (rst),
                .in_valid (iv[d]),
                .in_ready (ir[d]),
                .state_in (sin[d]),
                .out_valid(ov[d]),
                .out_ready(ordy[d]),
                .state_out(so[d]),
                .busy     (by[d])
            );

            logic [127:0] q[$];
            int           acc_q[$];
            bit           seen = 1'b0;
            int           cyc  = 0;

            // Inputs only change just after posedge, so the negedge sees what the next edge will do.
            always @(negedge clk) begin
                cyc++;
                if (rst) begin
                    q.delete();
                    acc_q.delete();
                    seen = 1'b0;
                end else begin
                    if (ov[d]) begin
                        if (q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL spurious_out dut%0d: got %h expected no output", d, so[d]);
                        end else begin
                            check128($sformatf("data dut%0d", d), so[d], q[0]);
                            if (!seen) begin
                                check_int($sformatf("latency dut%0d", d), cyc - acc_q[0] - 1, NC);
                                seen = 1'b1;
                            end
                        end
                        if (ordy[d]) begin
                            if (q.size() > 0) begin
                                void'(q.pop_front());
                                void'(acc_q.pop_front());
                            end
                            seen = 1'b0;
                        end
                    end
                    if (iv[d] && ir[d]) begin
                        q.push_back(xin[d]);
                        acc_q.push_back(cyc);
                    end
                end
            end
        end
    endgenerate

    task automatic send(input int d, input logic [127:0] data, input logic [127:0] exp);
        bit ok;
        ok     = 1'b0;
        sin[d] = data;
        xin[d] = exp;
        iv[d]  = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (ir[d]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout dut%0d: in_ready got 0 expected 1", d);
        end
        @(posedge clk);
        #1;
        iv[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (!by[d] && !ov[d]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout dut%0d: busy got 1 expected 0", d);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] rd;
        logic [7:0]   f;
        for (int x = 0; x < 256; x++) begin
            f        = sbox_calc(8'(x));
            fwd_t[x] = f;
            inv_t[f] = 8'(x);
        end

        rst = 1'b1;
        for (int d = 0; d < c_ND; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b1; sin[d] = '0; xin[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        for (int d = 0; d < c_ND; d++) begin
            check_int("reset in_ready", int'(ir[d]), 1);
            check_int("reset out_valid", int'(ov[d]), 0);
            check_int("reset busy", int'(by[d]), 0);
            check128("reset state_out", so[d], '0);
        end
        @(posedge clk);
        #1;

        // FIPS-197 Appendix B round 1, with in_ready low for the four RUN cycles.
        send(0, c_APPB_IN, c_APPB_OUT);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_int("in_ready during run", int'(ir[0]), 0);
        end
        wait_idle(0);

        send(0, '0, {16{8'h63}});
        send(0, '1, {16{8'h16}});
        wait_idle(0);
        send(1, {16{8'h63}}, '0);
        send(1, {16{8'hed}}, {16{8'h53}});
        send(1, c_APPB_OUT, c_APPB_IN);
        wait_idle(1);

        // Backpressure in DONE, then a simultaneous handoff.
        ordy[0] = 1'b0;
        send(0, c_APPB_IN, c_APPB_OUT);
        for (int t = 0; t < 50 && !ov[0]; t++) @(negedge clk);
        repeat (10) begin
            @(negedge clk);
            check_int("bp out_valid", int'(ov[0]), 1);
            check_int("bp in_ready", int'(ir[0]), 0);
            check128("bp state_out", so[0], c_APPB_OUT);
        end
        @(posedge clk);
        #1;
        ordy[0] = 1'b1;
        send(0, '1, {16{8'h16}});
        @(negedge clk);
        check_int("handoff out_valid", int'(ov[0]), 0);
        check_int("handoff busy", int'(by[0]), 1);
        wait_idle(0);

        drv_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 100; n++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    rd = {$urandom, $urandom, $urandom, $urandom};
                    send(0, rd, sub_state(rd, 1'b0));
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk);
                    #1;
                    ordy[0] = ($urandom_range(0, 3) != 0);
                end
                ordy[0] = 1'b1;
            end
        join
        wait_idle(0);
        for (int n = 0; n < 20; n++) begin
            rd = {$urandom, $urandom, $urandom, $urandom};
            send(1, rd, sub_state(rd, 1'b1));
        end
        wait_idle(1);

        // Reset lands on the second RUN cycle; the partial state is discarded.
        send(0, c_APPB_IN, c_APPB_OUT);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_int("midrst out_valid", int'(ov[0]), 0);
        check_int("midrst busy", int'(by[0]), 0);
        check_int("midrst in_ready", int'(ir[0]), 1);
        check128("midrst state_out", so[0], '0);
        @(posedge clk);
        #1;
        send(0, c_APPB_IN, c_APPB_OUT);
        wait_idle(0);

        fork
            send(2, c_APPB_IN, c_APPB_OUT);
            send(3, c_APPB_IN, c_APPB_OUT);
            send(4, c_APPB_IN, c_APPB_OUT);
            send(5, c_APPB_IN, c_APPB_OUT);
        join
        for (int d = 2; d < c_ND; d++) wait_idle(d);

        check_int("drain dut0", g_dut[0].q.size(), 0);
        check_int("drain dut1", g_dut[1].q.size(), 0);
        check_int("drain dut2", g_dut[2].q.size(), 0);
        check_int("drain dut3", g_dut[3].q.size(), 0);
        check_int("drain dut4", g_dut[4].q.size(), 0);
        check_int("drain dut5", g_dut[5].q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
